// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core: widths, reset PC, opcode map,
// instruction field positions and the IF/ID pipeline payload.
package risc_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 16;

  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned OFFSET_MSB = 5;
  localparam int unsigned OFFSET_LSB = 0;
  localparam int unsigned JFIELD_MSB = 11;
  localparam int unsigned JFIELD_LSB = 0;

  localparam int unsigned OFFSET_W = OFFSET_MSB - OFFSET_LSB + 1;
  localparam int unsigned JFIELD_W = JFIELD_MSB - JFIELD_LSB + 1;

  typedef enum logic [3:0] {
    OP_LW  = 4'h0,
    OP_SW  = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_INV = 4'h4,
    OP_LSL = 4'h5,
    OP_LSR = 4'h6,
    OP_AND = 4'h7,
    OP_OR  = 4'h8,
    OP_SLT = 4'h9,
    OP_BEQ = 4'hB,
    OP_BNE = 4'hC,
    OP_JMP = 4'hD
  } opcode_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_plus2;
    logic               valid;
  } ifid_t;

  function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, control-unit feedback and IF/ID outputs.
interface fetch_stage_if;
  import risc_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic               imem_en;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               jump;
  logic               beq;
  logic               bne;
  logic               cmp_eq;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc_plus2;
  logic               id_valid;

  modport master (
    output imem_addr, imem_en, id_instr, id_pc_plus2, id_valid,
    input  imem_rdata, stall, jump, beq, bne, cmp_eq
  );

  modport slave (
    input  imem_addr, imem_en, id_instr, id_pc_plus2, id_valid,
    output imem_rdata, stall, jump, beq, bne, cmp_eq
  );

endinterface

// File: rtl/branch_target_calc.sv
// Combinational redirect targets for the instruction sitting in ID.
module branch_target_calc
  import risc_pkg::*;
(
  input  logic [PC_W-1:0]    id_pc_plus2_i,
  input  logic [INSTR_W-1:0] id_instr_i,
  output logic [PC_W-1:0]    branch_target_c_o,
  output logic [PC_W-1:0]    jump_target_c_o
);

  localparam int unsigned SEXT_W = PC_W - OFFSET_W - 1;

  logic [OFFSET_W-1:0] offset;
  logic [JFIELD_W-1:0] jfield;
  logic [PC_W-1:0]     offset_bytes;
  logic                unused_opcode;

  assign offset = id_instr_i[OFFSET_MSB:OFFSET_LSB];
  assign jfield = id_instr_i[JFIELD_MSB:JFIELD_LSB];

  // Word offset is sign-extended and scaled to bytes.
  assign offset_bytes      = {{SEXT_W{offset[OFFSET_W-1]}}, offset, 1'b0};
  assign branch_target_c_o = PC_W'(id_pc_plus2_i + offset_bytes);
  assign jump_target_c_o   = {id_pc_plus2_i[PC_W-1:PC_W-3], jfield, 1'b0};

  assign unused_opcode = ^id_instr_i[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register; resolves jumps and branches in ID and
// redirects fetch with a two-bubble penalty.
module fetch_stage
  import risc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = risc_pkg::RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam logic [PC_W-1:0] PC_INCR  = PC_W'(2);
  localparam logic [PC_W-1:0] PC_START = {RESET_PC[PC_W-1:1], 1'b0};

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] f_pc_q, f_pc_d;
  logic            f_valid_q, f_valid_d;
  ifid_t           ifid_q, ifid_d;

  logic [PC_W-1:0] branch_target_c;
  logic [PC_W-1:0] jump_target_c;
  logic [PC_W-1:0] target_c;
  logic            taken_c;

  branch_target_calc u_target (
    .id_pc_plus2_i     (ifid_q.pc_plus2),
    .id_instr_i        (ifid_q.instr),
    .branch_target_c_o (branch_target_c),
    .jump_target_c_o   (jump_target_c)
  );

  // Redirect decision; a stalled cycle never redirects.
  always_comb begin
    taken_c  = ifid_q.valid & ~bus.stall &
               (bus.jump | (bus.beq & bus.cmp_eq) | (bus.bne & ~bus.cmp_eq));
    target_c = bus.jump ? jump_target_c : branch_target_c;
  end

  // Next state: stall holds, taken flushes, otherwise advance one slot.
  always_comb begin
    pc_d      = pc_q;
    f_pc_d    = f_pc_q;
    f_valid_d = f_valid_q;
    ifid_d    = ifid_q;
    if (!bus.stall) begin
      if (taken_c) begin
        pc_d         = target_c;
        f_valid_d    = 1'b0;
        ifid_d.valid = 1'b0;
        ifid_d.instr = '0;
      end else begin
        pc_d            = PC_W'(pc_q + PC_INCR);
        f_pc_d          = pc_q;
        f_valid_d       = 1'b1;
        ifid_d.instr    = bus.imem_rdata;
        ifid_d.pc_plus2 = PC_W'(f_pc_q + PC_INCR);
        ifid_d.valid    = f_valid_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= PC_START;
      f_pc_q    <= '0;
      f_valid_q <= 1'b0;
      ifid_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      f_pc_q    <= f_pc_d;
      f_valid_q <= f_valid_d;
      ifid_q    <= ifid_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.imem_en     = ~bus.stall;
  assign bus.id_instr    = ifid_q.instr;
  assign bus.id_pc_plus2 = ifid_q.pc_plus2;
  assign bus.id_valid    = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: three instances (reset PC 0, FFFE, 4008)
// each fed by a synchronous ROM model and a small opcode decoder.
module tb_fetch_stage;
  import risc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  int   checks = 0;
  int   errors = 0;

  fetch_stage_if if0 ();
  fetch_stage_if if1 ();
  fetch_stage_if if2 ();

  fetch_stage u_dut0 (.clk(clk), .rst(rst0), .bus(if0.master));
  fetch_stage #(.RESET_PC(16'hFFFE)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1.master));
  fetch_stage #(.RESET_PC(16'h4008)) u_dut2 (.clk(clk), .rst(rst2), .bus(if2.master));

  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hB003;
      16'h0020: return 16'hC03E;
      16'h4010: return 16'hD123;
      default:  return 16'h2000 | {1'b0, a[15:1]};
    endcase
  endfunction

  always @(posedge clk) if (if0.imem_en) if0.imem_rdata <= rom(if0.imem_addr);
  always @(posedge clk) if (if1.imem_en) if1.imem_rdata <= rom(if1.imem_addr);
  always @(posedge clk) if (if2.imem_en) if2.imem_rdata <= rom(if2.imem_addr);

  assign if0.jump = (if0.id_instr[15:12] == OP_JMP);
  assign if0.beq  = (if0.id_instr[15:12] == OP_BEQ);
  assign if0.bne  = (if0.id_instr[15:12] == OP_BNE);
  assign if1.jump = (if1.id_instr[15:12] == OP_JMP);
  assign if1.beq  = (if1.id_instr[15:12] == OP_BEQ);
  assign if1.bne  = (if1.id_instr[15:12] == OP_BNE);
  assign if2.jump = (if2.id_instr[15:12] == OP_JMP);
  assign if2.beq  = (if2.id_instr[15:12] == OP_BEQ);
  assign if2.bne  = (if2.id_instr[15:12] == OP_BNE);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic [15:0] instr,
                        input logic [15:0] pp2, input logic [15:0] addr);
    chk({tag, "_valid"}, 16'(if0.id_valid), 16'h0001);
    chk({tag, "_instr"}, if0.id_instr, instr);
    chk({tag, "_pp2"}, if0.id_pc_plus2, pp2);
    chk({tag, "_addr"}, if0.imem_addr, addr);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    if0.stall = 1'b0; if0.cmp_eq = 1'b0;
    if1.stall = 1'b0; if1.cmp_eq = 1'b0;
    if2.stall = 1'b0; if2.cmp_eq = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_addr", if0.imem_addr, 16'h0000);
    chk("rst_valid", 16'(if0.id_valid), 16'h0000);
    chk("rst_instr", if0.id_instr, 16'h0000);
    chk("rst_pp2", if0.id_pc_plus2, 16'h0000);
    chk("rst_en", 16'(if0.imem_en), 16'h0001);
    chk("rst1_addr", if1.imem_addr, 16'hFFFE);
    chk("rst2_addr", if2.imem_addr, 16'h4008);

    // Reset release, sequential fetch
    rst0 = 1'b0;
    @(negedge clk);
    chk("seq1_addr", if0.imem_addr, 16'h0002);
    chk("seq1_valid", 16'(if0.id_valid), 16'h0000);
    @(negedge clk);
    chk_id("seq2", 16'h2000, 16'h0002, 16'h0004);
    @(negedge clk);
    chk_id("seq3", 16'h2001, 16'h0004, 16'h0006);

    // BEQ reaches ID, stalled for 3 cycles, then taken
    repeat (7) @(negedge clk);
    chk_id("beq_id", 16'hB003, 16'h0012, 16'h0014);
    if0.stall = 1'b1; if0.cmp_eq = 1'b1;
    #1 chk("stall_en", 16'(if0.imem_en), 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_id("stall_hold", 16'hB003, 16'h0012, 16'h0014);
      chk("stall_en_hold", 16'(if0.imem_en), 16'h0000);
    end
    if0.stall = 1'b0;
    @(negedge clk);
    chk("beq_tgt_addr", if0.imem_addr, 16'h0018);
    chk("beq_bubble1", 16'(if0.id_valid), 16'h0000);
    @(negedge clk);
    chk("beq_bubble2", 16'(if0.id_valid), 16'h0000);
    chk("beq_addr2", if0.imem_addr, 16'h001A);
    @(negedge clk);
    chk_id("beq_tgt", 16'h200C, 16'h001A, 16'h001C);
    if0.cmp_eq = 1'b0;

    // BNE with negative offset, taken
    repeat (4) @(negedge clk);
    chk_id("bne_id", 16'hC03E, 16'h0022, 16'h0024);
    @(negedge clk);
    chk("bne_tgt_addr", if0.imem_addr, 16'h001E);
    chk("bne_bubble1", 16'(if0.id_valid), 16'h0000);
    @(negedge clk);
    chk("bne_bubble2", 16'(if0.id_valid), 16'h0000);
    @(negedge clk);
    chk_id("bne_tgt", 16'h200F, 16'h0020, 16'h0022);
    if0.cmp_eq = 1'b1;

    // BNE again, not taken: falls through with no bubble
    @(negedge clk);
    chk_id("bne_nt_id", 16'hC03E, 16'h0022, 16'h0024);
    @(negedge clk);
    chk_id("bne_nt_next", 16'h2011, 16'h0024, 16'h0026);

    // PC wrap from FFFE
    rst1 = 1'b0;
    @(negedge clk);
    chk("wrap_addr", if1.imem_addr, 16'h0000);
    @(negedge clk);
    chk("wrap_valid", 16'(if1.id_valid), 16'h0001);
    chk("wrap_instr", if1.id_instr, 16'h7FFF);
    chk("wrap_pp2", if1.id_pc_plus2, 16'h0000);
    chk("wrap_addr2", if1.imem_addr, 16'h0002);

    // JMP at 0x4010
    rst2 = 1'b0;
    repeat (6) @(negedge clk);
    chk("jmp_id_instr", if2.id_instr, 16'hD123);
    chk("jmp_id_pp2", if2.id_pc_plus2, 16'h4012);
    chk("jmp_id_addr", if2.imem_addr, 16'h4014);
    @(negedge clk);
    chk("jmp_tgt_addr", if2.imem_addr, 16'h4246);
    chk("jmp_bubble1", 16'(if2.id_valid), 16'h0000);
    @(negedge clk);
    chk("jmp_bubble2", 16'(if2.id_valid), 16'h0000);
    @(negedge clk);
    chk("jmp_tgt_valid", 16'(if2.id_valid), 16'h0001);
    chk("jmp_tgt_instr", if2.id_instr, 16'h2123);
    chk("jmp_tgt_pp2", if2.id_pc_plus2, 16'h4248);

    // Reset on the edge a JMP would be taken
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    repeat (6) @(negedge clk);
    chk("rjmp_id_instr", if2.id_instr, 16'hD123);
    rst2 = 1'b1;
    @(negedge clk);
    chk("rjmp_addr", if2.imem_addr, 16'h4008);
    chk("rjmp_valid", 16'(if2.id_valid), 16'h0000);
    chk("rjmp_fvalid", 16'(u_dut2.f_valid_q), 16'h0000);
    chk("rjmp_instr", if2.id_instr, 16'h0000);
    rst2 = 1'b0;
    @(negedge clk);
    chk("rjmp_addr1", if2.imem_addr, 16'h400A);
    chk("rjmp_valid1", 16'(if2.id_valid), 16'h0000);
    @(negedge clk);
    chk("rjmp_valid2", 16'(if2.id_valid), 16'h0001);
    chk("rjmp_instr2", if2.id_instr, 16'h2004);
    chk("rjmp_pp2", if2.id_pc_plus2, 16'h400A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
